// File: rtl/pc_redirect_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl_pkg
// Shared types and helpers for the fetch PC redirect controller.
//   redir_src_e : redirect source, encoded so a larger value means higher priority
//   state_e     : sequencer state (IDLE / PEND)
//   INSTR_BYTES : sequential fetch step
//   align_word / is_misaligned : target alignment helpers
// -----------------------------------------------------------------------------
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ID   = 2'd1,
    SRC_EX   = 2'd2,
    SRC_TRAP = 2'd3
  } redir_src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Force a target onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // A target is misaligned when either of its two low bits is set.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_prio_arb.sv
// -----------------------------------------------------------------------------
// redirect_prio_arb
// Combinational fixed-priority picker over three redirect slots:
// TRAP > EX > ID. Outputs SRC_NONE and a zero target when nothing requests.
// Ports:
//   trap_req/trap_addr, ex_req/ex_target, id_req/id_target : candidate slots
//   win_src    : winning source
//   win_target : target of the winning source
// -----------------------------------------------------------------------------
module redirect_prio_arb
  import pc_redirect_ctrl_pkg::*;
(
  input  logic        trap_req,
  input  logic [31:0] trap_addr,
  input  logic        ex_req,
  input  logic [31:0] ex_target,
  input  logic        id_req,
  input  logic [31:0] id_target,
  output redir_src_e  win_src,
  output logic [31:0] win_target
);

  // Fixed-priority selection of the highest requesting slot.
  always_comb begin
    win_src    = SRC_NONE;
    win_target = 32'h0000_0000;
    if (trap_req) begin
      win_src    = SRC_TRAP;
      win_target = trap_addr;
    end else if (ex_req) begin
      win_src    = SRC_EX;
      win_target = ex_target;
    end else if (id_req) begin
      win_src    = SRC_ID;
      win_target = id_target;
    end else begin
      win_src    = SRC_NONE;
      win_target = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
// Next-PC sequencer owning the fetch PC. Arbitrates CSR trap/return, EX
// mispredict and ID early-jump redirects against sequential fetch and stall.
// A redirect that cannot be issued (fetch_ready=0) is buffered (PEND) and
// replayed when imem is ready; only a strictly higher-priority request may
// replace the buffered one.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   trap_req/trap_addr       : CSR trap/mret redirect
//   ex_redirect/ex_target    : EX-stage branch resolve / indirect jump
//   id_jump/id_target        : ID-stage early jump
//   stall                    : hazard stall, blocks sequential advance only
//   fetch_ready              : imem accepts a new address this cycle
//   pc                       : registered fetch PC
//   flush_if, flush_id       : pipeline kill strobes (combinational)
//   redirect_pending         : a redirect is buffered
//   misalign_err             : one-cycle pulse, applied target had bits[1:0]!=0
//   redirect_cnt             : saturating count of applied redirects
// -----------------------------------------------------------------------------
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trap_req,
  input  logic [31:0]      trap_addr,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             id_jump,
  input  logic [31:0]      id_target,
  input  logic             stall,
  input  logic             fetch_ready,
  output logic [31:0]      pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             redirect_pending,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  redir_src_e       pend_src_r;
  logic [31:0]      pend_target_r;
  logic [31:0]      pc_r;
  logic             misalign_r;
  logic [CNT_W-1:0] cnt_r;

  redir_src_e  in_src_s;
  logic [31:0] in_target_s;
  redir_src_e  eff_src_s;
  logic [31:0] eff_target_s;

  logic        slot_trap_req_s, slot_ex_req_s, slot_id_req_s;
  logic [31:0] slot_trap_tgt_s, slot_ex_tgt_s, slot_id_tgt_s;

  // Winner among the requests raised this cycle.
  redirect_prio_arb u_in_arb (
    .trap_req   (trap_req),
    .trap_addr  (trap_addr),
    .ex_req     (ex_redirect),
    .ex_target  (ex_target),
    .id_req     (id_jump),
    .id_target  (id_target),
    .win_src    (in_src_s),
    .win_target (in_target_s)
  );

  // Merge the incoming winner with the buffered redirect into per-priority
  // slots. When both occupy the same slot the buffered one is kept, since it
  // comes from an older instruction; so only a strictly higher source wins.
  // In IDLE the buffer is SRC_NONE and the incoming winner passes through.
  always_comb begin
    slot_trap_req_s = (in_src_s == SRC_TRAP) || (pend_src_r == SRC_TRAP);
    slot_ex_req_s   = (in_src_s == SRC_EX)   || (pend_src_r == SRC_EX);
    slot_id_req_s   = (in_src_s == SRC_ID)   || (pend_src_r == SRC_ID);
    if (pend_src_r == SRC_TRAP) begin
      slot_trap_tgt_s = pend_target_r;
    end else begin
      slot_trap_tgt_s = in_target_s;
    end
    if (pend_src_r == SRC_EX) begin
      slot_ex_tgt_s = pend_target_r;
    end else begin
      slot_ex_tgt_s = in_target_s;
    end
    if (pend_src_r == SRC_ID) begin
      slot_id_tgt_s = pend_target_r;
    end else begin
      slot_id_tgt_s = in_target_s;
    end
  end

  // Effective redirect: buffered entry vs. incoming winner.
  redirect_prio_arb u_eff_arb (
    .trap_req   (slot_trap_req_s),
    .trap_addr  (slot_trap_tgt_s),
    .ex_req     (slot_ex_req_s),
    .ex_target  (slot_ex_tgt_s),
    .id_req     (slot_id_req_s),
    .id_target  (slot_id_tgt_s),
    .win_src    (eff_src_s),
    .win_target (eff_target_s)
  );

  // Flush strobes from the current request and state.
  always_comb begin
    flush_if = 1'b0;
    flush_id = 1'b0;
    if ((in_src_s != SRC_NONE) || (state_r == ST_PEND)) begin
      flush_if = 1'b1;
    end else begin
      flush_if = 1'b0;
    end
    if ((eff_src_s == SRC_TRAP) || (eff_src_s == SRC_EX)) begin
      flush_id = 1'b1;
    end else begin
      flush_id = 1'b0;
    end
  end

  // State, PC, redirect buffer, misalign pulse and redirect counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      pend_src_r    <= SRC_NONE;
      pend_target_r <= 32'h0000_0000;
      pc_r          <= RESET_VECTOR;
      misalign_r    <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
    end else begin
      misalign_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (eff_src_s != SRC_NONE) begin
            if (fetch_ready) begin
              pc_r       <= align_word(eff_target_s);
              misalign_r <= is_misaligned(eff_target_s);
              if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end else begin
              state_r       <= ST_PEND;
              pend_src_r    <= eff_src_s;
              pend_target_r <= eff_target_s;
            end
          end else if (fetch_ready && !stall) begin
            pc_r <= pc_r + INSTR_BYTES;
          end
        end
        ST_PEND: begin
          // stall does not matter here: a redirect always wins over it.
          if (fetch_ready) begin
            pc_r          <= align_word(eff_target_s);
            misalign_r    <= is_misaligned(eff_target_s);
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + CNT_ONE;
            end
            state_r       <= ST_IDLE;
            pend_src_r    <= SRC_NONE;
            pend_target_r <= 32'h0000_0000;
          end else begin
            pend_src_r    <= eff_src_s;
            pend_target_r <= eff_target_s;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          pend_src_r <= SRC_NONE;
        end
      endcase
    end
  end

  assign pc               = pc_r;
  assign redirect_pending = (state_r == ST_PEND);
  assign misalign_err     = misalign_r;
  assign redirect_cnt     = cnt_r;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_ctrl
// Directed walk through the main scenarios followed by randomized traffic,
// all compared against a behavioural next-PC model. A narrow counter width
// is used so saturation is reached during the random phase.
// -----------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

  localparam int          TB_CNT_W = 4;
  localparam logic [31:0] RV       = 32'h0000_0000;

  logic                clk;
  logic                rst;
  logic                trap_req;
  logic [31:0]         trap_addr;
  logic                ex_redirect;
  logic [31:0]         ex_target;
  logic                id_jump;
  logic [31:0]         id_target;
  logic                stall;
  logic                fetch_ready;
  logic [31:0]         pc;
  logic                flush_if;
  logic                flush_id;
  logic                redirect_pending;
  logic                misalign_err;
  logic [TB_CNT_W-1:0] redirect_cnt;

  pc_redirect_ctrl #(
    .RESET_VECTOR (RV),
    .CNT_W        (TB_CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .trap_req         (trap_req),
    .trap_addr        (trap_addr),
    .ex_redirect      (ex_redirect),
    .ex_target        (ex_target),
    .id_jump          (id_jump),
    .id_target        (id_target),
    .stall            (stall),
    .fetch_ready      (fetch_ready),
    .pc               (pc),
    .flush_if         (flush_if),
    .flush_id         (flush_id),
    .redirect_pending (redirect_pending),
    .misalign_err     (misalign_err),
    .redirect_cnt     (redirect_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: priority 0 means no redirect.
  logic [31:0] m_pc;
  bit          m_pend;
  int          m_pend_p;
  logic [31:0] m_pend_t;
  int          m_cnt;
  bit          m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check flush mid-cycle, clock, check state.
  task automatic step(input bit r, input bit tr, input logic [31:0] ta,
                      input bit er, input logic [31:0] et,
                      input bit ir, input logic [31:0] it,
                      input bit st, input bit fr);
    bit          req[4];
    logic [31:0] tgt[4];
    int          win_p, eff_p;
    logic [31:0] win_t, eff_t;
    rst = r; trap_req = tr; trap_addr = ta; ex_redirect = er; ex_target = et;
    id_jump = ir; id_target = it; stall = st; fetch_ready = fr;
    req[0] = 1'b0; tgt[0] = 32'h0;
    req[1] = ir;   tgt[1] = it;
    req[2] = er;   tgt[2] = et;
    req[3] = tr;   tgt[3] = ta;
    win_p = 0; win_t = 32'h0;
    for (int p = 3; p >= 1; p--) begin
      if (req[p] && win_p == 0) begin
        win_p = p;
        win_t = tgt[p];
      end
    end
    // An older buffered redirect keeps precedence over equal/lower requests.
    if (m_pend && m_pend_p >= win_p) begin
      eff_p = m_pend_p; eff_t = m_pend_t;
    end else begin
      eff_p = win_p; eff_t = win_t;
    end
    #3;
    if (!r) begin
      check("flush_if", 32'(flush_if), 32'(win_p > 0 || m_pend));
      check("flush_id", 32'(flush_id), 32'(eff_p >= 2));
    end
    @(posedge clk);
    m_mis = 1'b0;
    if (r) begin
      m_pc = RV; m_pend = 1'b0; m_pend_p = 0; m_pend_t = 32'h0; m_cnt = 0;
    end else if (eff_p > 0) begin
      if (fr) begin
        m_pc   = eff_t & 32'hFFFF_FFFC;
        m_mis  = (eff_t % 4) != 0;
        if (m_cnt < (1 << TB_CNT_W) - 1) m_cnt++;
        m_pend = 1'b0; m_pend_p = 0;
      end else begin
        m_pend = 1'b1; m_pend_p = eff_p; m_pend_t = eff_t;
      end
    end else if (fr && !st) begin
      m_pc = m_pc + 32'd4;
    end
    #1;
    check("pc", pc, m_pc);
    check("pending", 32'(redirect_pending), 32'(m_pend));
    check("misalign", 32'(misalign_err), 32'(m_mis));
    check("cnt", 32'(redirect_cnt), 32'(m_cnt));
  endtask

  initial begin
    bit tr, er, ir, st, fr, r;
    rst = 1'b1; trap_req = 1'b0; trap_addr = 32'h0; ex_redirect = 1'b0; ex_target = 32'h0;
    id_jump = 1'b0; id_target = 32'h0; stall = 1'b0; fetch_ready = 1'b0;
    m_pc = RV; m_pend = 1'b0; m_pend_p = 0; m_pend_t = 32'h0; m_cnt = 0; m_mis = 1'b0;
    @(posedge clk);
    #1;

    // Reset, sequential fetch, then stall hold.
    step(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1);
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_cnt", 32'(redirect_cnt), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1);
    check("seq_pc", pc, 32'h0000_000C);
    for (int i = 0; i < 2; i++) step(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 1);
    check("stall_pc", pc, 32'h0000_000C);

    // Simultaneous requests: trap wins.
    step(0, 1, 32'h100, 1, 32'h200, 1, 32'h300, 0, 1);
    check("prio_pc", pc, 32'h0000_0100);
    check("prio_cnt", 32'(redirect_cnt), 32'd1);

    // Buffer ID, replace with EX, then apply while a lower ID arrives.
    step(0, 0, 32'h0, 0, 32'h0, 1, 32'h40, 0, 0);
    check("pend_set", 32'(redirect_pending), 32'd1);
    step(0, 0, 32'h0, 1, 32'h80, 0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 0, 32'h0, 1, 32'h90, 0, 1);
    check("replay_pc", pc, 32'h0000_0080);
    check("replay_pend", 32'(redirect_pending), 32'd0);

    // Misaligned EX target applied under stall.
    step(0, 0, 32'h0, 1, 32'h106, 0, 32'h0, 1, 1);
    check("mis_pc", pc, 32'h0000_0104);
    check("mis_pulse", 32'(misalign_err), 32'd1);
    step(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0);
    check("mis_clear", 32'(misalign_err), 32'd0);

    // PC wrap at the top of the address space.
    step(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 1);
    step(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1);
    check("wrap_pc", pc, 32'h0000_0000);

    // Reset while a redirect is buffered discards it.
    step(0, 0, 32'h0, 0, 32'h0, 1, 32'h440, 0, 0);
    step(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
    check("rstpend_pc", pc, RV);
    check("rstpend_flag", 32'(redirect_pending), 32'd0);
    step(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1);
    check("rstpend_next", pc, RV + 32'd4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(99) < 2);
      tr = ($urandom_range(99) < 10);
      er = ($urandom_range(99) < 15);
      ir = ($urandom_range(99) < 20);
      st = ($urandom_range(99) < 30);
      fr = ($urandom_range(99) < 65);
      step(r, tr, $urandom, er, $urandom, ir, $urandom, st, fr);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
